// File: rtl/imem_sram_bist.sv
// 2^ADDR_W x DATA_W single-port synchronous SRAM with a built-in two-pass
// write/read-verify self-test engine that borrows the port while busy.
module imem_sram_bist #(
    parameter int                 ADDR_W  = 9,
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  PATTERN = 32'hA5A5_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic                we,
    output logic [DATA_W-1:0]   dout,
    input  logic                start,
    input  logic                fault_en,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD0, S_WR1, S_RD1} state_t;

    localparam logic [ADDR_W:0] LAST_WR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] LAST_RD = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ERR_MAX = {(ADDR_W+1){1'b1}};

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic [DATA_W-1:0]   dout_q;

    logic [ADDR_W-1:0]   bist_a, prev_a, mem_addr;
    logic [DATA_W-1:0]   exp_word, mem_wdata, flip;
    logic                mem_we, mismatch, busy_w;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return PATTERN ^ DATA_W'(a);
    endfunction

    assign busy_w = (state_q != S_IDLE);
    assign bist_a = cnt_q[ADDR_W-1:0];
    // dout in a read phase holds the word addressed one cycle earlier
    assign prev_a = bist_a - ADDR_W'(1);

    always_comb begin
        flip      = '0;
        exp_word  = pat(prev_a);
        mismatch  = 1'b0;
        mem_addr  = addr;
        mem_wdata = din;
        mem_we    = we;
        if (state_q == S_RD1) begin
            exp_word = ~pat(prev_a);
        end
        if ((state_q == S_RD0 || state_q == S_RD1) && cnt_q != '0) begin
            mismatch = (dout_q != exp_word);
        end
        if (state_q == S_WR0 && fault_q && bist_a == ADDR_W'(5)) begin
            flip = DATA_W'(1);
        end
        if (busy_w) begin
            mem_addr  = bist_a;
            mem_we    = (state_q == S_WR0 || state_q == S_WR1);
            mem_wdata = (state_q == S_WR1) ? ~pat(bist_a) : (pat(bist_a) ^ flip);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                ferr_d = prev_a;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR0;
                    cnt_d   = '0;
                    fault_d = fault_en;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ferr_d  = '0;
                end
            end
            S_WR0, S_WR1: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WR) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                end
            end
            S_RD0: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_RD) begin
                    cnt_d   = '0;
                    state_d = S_WR1;
                end
            end
            S_RD1: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_RD) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            dout_q  <= mem[mem_addr];
        end
    end

    assign dout           = dout_q;
    assign busy           = busy_w;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_imem_sram_bist.sv
// Directed bench for imem_sram_bist: external port behaviour, BIST pass/fail,
// port lockout while busy and reset abort.
module tb_imem_sram_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
    logic        start;
    logic        fault_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  err_count;
    logic [8:0]  first_err_addr;

    int checks = 0;
    int errors = 0;

    imem_sram_bist dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we),
        .dout(dout), .start(start), .fault_en(fault_en), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the start edge until busy drops, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; start = 1'b0; fault_en = 1'b0;
        addr = '0; din = '0;
        tick(); tick();
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
        checks++; if (err_count !== 10'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
        checks++; if (first_err_addr !== 9'd0) begin errors++; $display("FAIL reset_ferr got %0d exp 0", first_err_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_ext_rw();
        we = 1'b1; addr = 9'h1FF; din = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        tick();
        checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL ext_read got %h exp deadbeef", dout); end
    endtask

    task automatic test_read_first();
        we = 1'b1; addr = 9'h010; din = 32'h0;
        tick();
        din = 32'h1;
        tick();
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL read_first_old got %h exp 0", dout); end
        we = 1'b0;
        tick();
        checks++; if (dout !== 32'h1) begin errors++; $display("FAIL read_first_new got %h exp 1", dout); end
    endtask

    task automatic test_bist_pass();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy got %b exp 1", busy); end
        wait_idle(n);
        checks++; if (n != 2050) begin errors++; $display("FAIL pass_cycles got %0d exp 2050", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got %b exp 1", pass); end
        checks++; if (err_count !== 10'd0) begin errors++; $display("FAIL pass_err got %0d exp 0", err_count); end
        checks++; if (first_err_addr !== 9'd0) begin errors++; $display("FAIL pass_ferr got %0d exp 0", first_err_addr); end
        addr = 9'd3;
        tick();
        checks++; if (dout !== 32'h5A5AFFFC) begin errors++; $display("FAIL pass_read3 got %h exp 5a5afffc", dout); end
    endtask

    task automatic test_bist_fault();
        int n;
        fault_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; fault_en = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fault_done_clr got %b exp 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fault_busy got %b exp 1", busy); end
        wait_idle(n);
        checks++; if (n != 2050) begin errors++; $display("FAIL fault_cycles got %0d exp 2050", n); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fault_pass got %b exp 0", pass); end
        checks++; if (err_count !== 10'd1) begin errors++; $display("FAIL fault_err got %0d exp 1", err_count); end
        checks++; if (first_err_addr !== 9'd5) begin errors++; $display("FAIL fault_ferr got %0d exp 5", first_err_addr); end
        addr = 9'd5;
        tick();
        checks++; if (dout !== 32'h5A5AFFFA) begin errors++; $display("FAIL fault_read5 got %h exp 5a5afffa", dout); end
    endtask

    task automatic test_ext_during_bist();
        int n;
        start = 1'b1;
        tick();
        we = 1'b1; addr = 9'd7; din = 32'h0;
        wait_idle(n);
        start = 1'b0; we = 1'b0;
        checks++; if (n != 2050) begin errors++; $display("FAIL lock_cycles got %0d exp 2050", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_done got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL lock_pass got %b exp 1", pass); end
        checks++; if (err_count !== 10'd0) begin errors++; $display("FAIL lock_err got %0d exp 0", err_count); end
        tick();
        checks++; if (dout !== 32'h5A5AFFF8) begin errors++; $display("FAIL lock_read7 got %h exp 5a5afff8", dout); end
    endtask

    task automatic test_reset_mid();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mid_pass got %b exp 0", pass); end
        checks++; if (err_count !== 10'd0) begin errors++; $display("FAIL mid_err got %0d exp 0", err_count); end
        checks++; if (first_err_addr !== 9'd0) begin errors++; $display("FAIL mid_ferr got %0d exp 0", first_err_addr); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL mid_dout got %h exp 0", dout); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b exp 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(n);
        checks++; if (n != 2050) begin errors++; $display("FAIL mid_cycles got %0d exp 2050", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done2 got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mid_pass2 got %b exp 1", pass); end
    endtask

    initial begin
        test_reset();
        test_ext_rw();
        test_read_first();
        test_bist_pass();
        test_bist_fault();
        test_ext_during_bist();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
